aes_top: RTL and testbench
==========================

Name: aes_top

Overview:
- AES-128 encryption engine (FIPS-197, encrypt only), iterative, one round per clock, with on-the-fly key expansion.
- Top-level crypto block: takes a 128-bit plaintext and a 128-bit key, produces a 128-bit ciphertext with a one-cycle valid strobe.
- No decryption and no key storage between operations; the key is sampled with each block.

Parameters:
- None. Key size fixed at 128 bits, 10 rounds.

Ports:
- AES_clk  in  1  clock; all logic on the rising edge.
- AES_rst  in  1  synchronous reset, active-high.
- AES_en  in  1  start request, level-sensitive; sampled only when idle.
- AES_data_in  in  128  plaintext; bit 127..120 = FIPS byte 0, column-major state.
- AES_key_in  in  128  cipher key; same byte order as the plaintext.
- AES_data_out  out  128  ciphertext; same byte order; held until the next completion.
- AES_data_out_valid  out  1  one-cycle pulse when AES_data_out updates.

Behaviour:
- Reset (AES_rst=1 at an edge):
  - busy=0, round counter=0.
  - AES_data_out=0, AES_data_out_valid=0, internal state and round-key registers=0.
  - Reset mid-operation aborts the block; no valid pulse is produced.
- States: IDLE (busy=0), RUN (busy=1, round counter r=1..10).
- IDLE with AES_en=1 at edge E0 (capture):
  - state <= AES_data_in XOR AES_key_in.
  - roundkey <= AES_key_in.
  - r <= 1, busy <= 1.
- RUN, each edge:
  - rk' = KeyExpand(roundkey, Rcon[r]); Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - KeyExpand: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk' for r<10; no MixColumns for r=10.
  - roundkey <= rk', r <= r+1.
- Completion at r=10 (edge E10):
  - AES_data_out <= final state; AES_data_out_valid <= 1 for exactly one cycle.
  - busy <= 0.
- Latency: AES_en sampled at E0 -> valid high in the cycle following E10 (10 clocks).
- AES_en, AES_data_in and AES_key_in are ignored while busy. Inputs may change freely after capture.
- AES_en still high in the valid cycle -> new capture at E11. Held-high AES_en gives back-to-back encryptions, one every 11 cycles.
- AES_data_out is stable between valid pulses; valid is low in every non-completion cycle.
- S-box: multiplicative inverse in GF(2^8) (poly 0x11B, 0 maps to 0) followed by the FIPS affine transform. May be implemented as a table or in composite-field logic. 20 instances: 16 for the state, 4 for key expansion.
- MixColumns uses xtime over 0x11B.

Optional Feature:
- Macro AES_COMPLEMENTARY_OUT_EN.
- Defined:
  - Adds outputs AES_data_out_complementary (128) and AES_data_out_complementary_valid (1).
  - AES_data_out_complementary = bitwise NOT of the ciphertext, registered on the same edge as AES_data_out.
  - Its valid pulses together with AES_data_out_valid.
  - Reset values: all-ones data, valid 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset AES_rst=1 for 2 cycles -> AES_data_out=0, AES_data_out_valid=0. AES_en=1 held during reset does not start an operation.
- Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, AES_en one cycle -> 10 cycles later a single valid pulse with AES_data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Changing inputs on the cycle after capture does not affect the result.
- Key 0, pt 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e. AES_en held high 51 cycles -> valid pulses every 11 cycles, same ciphertext each time, output held between pulses.
- Assert AES_rst at round 5 -> no valid pulse, AES_data_out=0. A fresh start afterwards gives the correct ciphertext.
- With AES_COMPLEMENTARY_OUT_EN: zero key/pt -> complementary output 9916b42b1075d3c477b305a635cbd4d1, pulsing with the primary valid.

Source files
------------

// File: rtl/aes_top.sv
// AES-128 encrypt core: iterative, one round per clock, on-the-fly key expansion.
// Optional complementary ciphertext outputs are enabled by defining AES_COMPLEMENTARY_OUT_EN.
module aes_top (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
`ifdef AES_COMPLEMENTARY_OUT_EN
  ,
  output logic [127:0] AES_data_out_complementary,
  output logic         AES_data_out_complementary_valid
`endif
);

  localparam int DATA_W = 128;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        fsm_p0;
  logic [3:0]        rnd_p0;
  logic [DATA_W-1:0] state_p0;
  logic [DATA_W-1:0] rkey_p0;
  logic [DATA_W-1:0] rkey_nxt;
  logic [DATA_W-1:0] round_out;
  logic [DATA_W-1:0] shifted;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (square-and-multiply), which maps 0 to 0; then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [DATA_W-1:0] sub_bytes(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte index is row + 4*column; row r rotates left by r columns.
  function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] mix_columns(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] kw0, kw1, kw2, kw3, ktmp;
  assign ktmp = sub_word({rkey_p0[23:0], rkey_p0[31:24]}) ^ {rcon(rnd_p0), 24'h000000};
  assign kw0  = rkey_p0[127:96] ^ ktmp;
  assign kw1  = rkey_p0[95:64] ^ kw0;
  assign kw2  = rkey_p0[63:32] ^ kw1;
  assign kw3  = rkey_p0[31:0] ^ kw2;
  assign rkey_nxt = {kw0, kw1, kw2, kw3};

  assign shifted   = shift_rows(sub_bytes(state_p0));
  assign round_out = ((rnd_p0 == 4'd10) ? shifted : mix_columns(shifted)) ^ rkey_nxt;

  // Round register stage; the output register stage updates only on the last round.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      fsm_p0             <= IDLE;
      rnd_p0             <= 4'd0;
      state_p0           <= '0;
      rkey_p0            <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
`ifdef AES_COMPLEMENTARY_OUT_EN
      AES_data_out_complementary       <= '1;
      AES_data_out_complementary_valid <= 1'b0;
`endif
    end else begin
      AES_data_out_valid <= 1'b0;
`ifdef AES_COMPLEMENTARY_OUT_EN
      AES_data_out_complementary_valid <= 1'b0;
`endif
      case (fsm_p0)
        IDLE: begin
          if (AES_en) begin
            state_p0 <= AES_data_in ^ AES_key_in;
            rkey_p0  <= AES_key_in;
            rnd_p0   <= 4'd1;
            fsm_p0   <= RUN;
          end
        end
        default: begin
          state_p0 <= round_out;
          rkey_p0  <= rkey_nxt;
          if (rnd_p0 == 4'd10) begin
            rnd_p0             <= 4'd0;
            fsm_p0             <= IDLE;
            AES_data_out       <= round_out;
            AES_data_out_valid <= 1'b1;
`ifdef AES_COMPLEMENTARY_OUT_EN
            AES_data_out_complementary       <= ~round_out;
            AES_data_out_complementary_valid <= 1'b1;
`endif
          end else begin
            rnd_p0 <= rnd_p0 + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Directed-vector bench for aes_top: FIPS-197 known answers, latency, back-to-back and abort.
module tb_aes_top;
  logic         AES_clk = 1'b0;
  logic         AES_rst;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
`ifdef AES_COMPLEMENTARY_OUT_EN
  logic [127:0] AES_data_out_complementary;
  logic         AES_data_out_complementary_valid;
`endif

  aes_top dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
`ifdef AES_COMPLEMENTARY_OUT_EN
    ,
    .AES_data_out_complementary       (AES_data_out_complementary),
    .AES_data_out_complementary_valid (AES_data_out_complementary_valid)
`endif
  );

  always #5 AES_clk = ~AES_clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_block(input vec_t v, input string name);
    int n;
    logic [127:0] got;
    AES_key_in  = v.key;
    AES_data_in = v.pt;
    AES_en      = 1'b1;
    tick();
    AES_en      = 1'b0;
    AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
    AES_data_in = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!AES_data_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'd10);
    chk({name, "_data"}, AES_data_out, v.ct);
`ifdef AES_COMPLEMENTARY_OUT_EN
    chk({name, "_comp"}, AES_data_out_complementary, ~v.ct);
    chk({name, "_comp_vld"}, 128'(AES_data_out_complementary_valid), 128'd1);
`endif
    got = AES_data_out;
    tick();
    chk({name, "_vld_drop"}, 128'(AES_data_out_valid), 128'd0);
    chk({name, "_held"}, AES_data_out, got);
  endtask

  initial begin
    int pulses;
    int last_i;
    int n;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // Reset with start held high
    AES_rst     = 1'b1;
    AES_en      = 1'b1;
    AES_key_in  = vecs[0].key;
    AES_data_in = vecs[0].pt;
    tick();
    tick();
    chk("reset_data", AES_data_out, 128'h0);
    chk("reset_vld", 128'(AES_data_out_valid), 128'd0);
`ifdef AES_COMPLEMENTARY_OUT_EN
    chk("reset_comp", AES_data_out_complementary, {128{1'b1}});
    chk("reset_comp_vld", 128'(AES_data_out_complementary_valid), 128'd0);
`endif
    AES_rst = 1'b0;
    AES_en  = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (AES_data_out_valid) pulses++;
    end
    chk("no_start_from_reset", 128'(pulses), 128'd0);

    for (int i = 0; i < 3; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Held-high start: back-to-back blocks every 11 cycles
    AES_key_in  = vecs[2].key;
    AES_data_in = vecs[2].pt;
    AES_en      = 1'b1;
    pulses      = 0;
    last_i      = 0;
    for (int i = 1; i <= 51; i++) begin
      tick();
      if (AES_data_out_valid) begin
        pulses++;
        chk("b2b_data", AES_data_out, vecs[2].ct);
        if (pulses == 1) chk("b2b_first_pos", 128'(i), 128'd11);
        else chk("b2b_spacing", 128'(i - last_i), 128'd11);
        last_i = i;
      end else if (pulses > 0) begin
        chk("b2b_held", AES_data_out, vecs[2].ct);
      end
    end
    chk("b2b_pulses", 128'(pulses), 128'd4);
    AES_en = 1'b0;
    n = 0;
    while (!AES_data_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_drain", 128'(AES_data_out_valid), 128'd1);
    tick();

    // Abort mid-block with reset
    AES_key_in  = vecs[1].key;
    AES_data_in = vecs[1].pt;
    AES_en      = 1'b1;
    tick();
    AES_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    AES_rst = 1'b1;
    tick();
    AES_rst = 1'b0;
    chk("abort_data", AES_data_out, 128'h0);
    chk("abort_vld", 128'(AES_data_out_valid), 128'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (AES_data_out_valid) pulses++;
    end
    chk("abort_no_pulse", 128'(pulses), 128'd0);
    chk("abort_data_hold", AES_data_out, 128'h0);
    run_block(vecs[1], "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
